catch_item: RTL and testbench

- Generalised catchable playfield object (gold, diamond, rock) for the gold-miner game, supporting NUM_CLAWS independent claws.
- Detects a claw tail touching an opaque sprite pixel and arbitrates simultaneous hooks.
- Drags the item along the hooking claw's direction at a weight-scaled speed.
- Resolves to COLLECTED (scored, one-cycle pulse) or DESTROYED (exploded, no score).
- One instance per item; the item manager supplies the origin and the VGA mixer consumes the pixel outputs.

---
 rtl/catch_pkg.sv | 64 ++++++
 rtl/catch_item_if.sv | 19 +
 rtl/catch_hit_pipe.sv | 40 ++++
 rtl/catch_item.sv | 182 ++++++++++++++++++
 tb/tb_catch_item.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/catch_pkg.sv
// catch_pkg: shared types and helpers for the catchable playfield item.
//   state_e      - item lifecycle states (encoding is visible on state_out)
//   delta_t      - signed per-step (dx,dy) for one claw direction
//   dir_delta()  - direction index -> per-step delta; unknown codes give (0,0)
//   sprite_addr()- row-major sprite ROM address of (x,y) relative to a box origin
//   in_box()     - inclusive bounding-box test, evaluated without 10-bit wrap
package catch_pkg;
  localparam int COORD_W   = 10;
  localparam int DIR_COUNT = 11;
  localparam int ADDR_W    = 19;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOOKED    = 3'd1,
    ST_COLLECTED = 3'd2,
    ST_DESTROYED = 3'd3
  } state_e;

  typedef struct packed {
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } delta_t;

  function automatic delta_t dir_delta(input logic [3:0] dir);
    delta_t d;
    d = '0;
    if (dir < 4'(DIR_COUNT)) begin
      case (dir)
        4'd0:    d = '{ 4'sd6,  4'sd0};
        4'd1:    d = '{ 4'sd6, -4'sd1};
        4'd2:    d = '{ 4'sd5, -4'sd2};
        4'd3:    d = '{ 4'sd4, -4'sd3};
        4'd4:    d = '{ 4'sd2, -4'sd4};
        4'd5:    d = '{ 4'sd0, -4'sd6};
        4'd6:    d = '{-4'sd2, -4'sd4};
        4'd7:    d = '{-4'sd4, -4'sd3};
        4'd8:    d = '{-4'sd5, -4'sd2};
        4'd9:    d = '{-4'sd6, -4'sd1};
        default: d = '{-4'sd6,  4'sd0};
      endcase
    end
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [COORD_W-1:0] x, y, px, py, input int w);
    logic [ADDR_W-1:0] dx, dy;
    dx = {9'b0, x} - {9'b0, px};
    dy = {9'b0, y} - {9'b0, py};
    return dy * ADDR_W'(w) + dx;
  endfunction

  // Extended to 11 bits so pos+size-1 near 1023 does not wrap to a tiny box.
  function automatic logic in_box(
    input logic [COORD_W-1:0] x, y, px, py, input int w, input int h);
    logic [COORD_W:0] xe, ye, pxe, pye;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    pxe = {1'b0, px};
    pye = {1'b0, py};
    return (xe >= pxe) && (xe <= pxe + 11'(w - 1)) &&
           (ye >= pye) && (ye <= pye + 11'(h - 1));
  endfunction
endpackage

// File: rtl/catch_item_if.sv
// catch_item_if: claw-side bus of one catchable item, packed per claw
// (claw 0 in the LSBs).
//   master = claw/ROM side: drives tails, direction, idle, explode, ROM result
//   slave  = item side: drives the tail ROM addresses and the hooked one-hot
interface catch_item_if #(parameter int NUM_CLAWS = 2);
  logic [NUM_CLAWS*10-1:0] tail_x;
  logic [NUM_CLAWS*10-1:0] tail_y;
  logic [NUM_CLAWS*4-1:0]  claw_dir;
  logic [NUM_CLAWS-1:0]    claw_idle;
  logic [NUM_CLAWS-1:0]    explode;
  logic [NUM_CLAWS*19-1:0] tail_addr;
  logic [NUM_CLAWS-1:0]    tail_opaque;
  logic [NUM_CLAWS-1:0]    hooked;

  modport master (output tail_x, tail_y, claw_dir, claw_idle, explode, tail_opaque,
                  input  tail_addr, hooked);
  modport slave  (input  tail_x, tail_y, claw_dir, claw_idle, explode, tail_opaque,
                  output tail_addr, hooked);
endinterface

// File: rtl/catch_hit_pipe.sv
// catch_hit_pipe: one claw's tail-contact pipeline.
//   Clk, clr_i            - clock, synchronous clear (reset | new_game)
//   tail_x_i/tail_y_i     - claw tail position, registered first
//   pos_x_i/pos_y_i       - current item top-left
//   tail_addr_o           - sprite ROM address of the registered tail
//   tail_opaque_i         - ROM answer, one cycle after tail_addr_o
//   hit_o                 - registered box test AND ROM opacity
module catch_hit_pipe import catch_pkg::*; #(
  parameter int ITEM_W = 20,
  parameter int ITEM_H = 20
) (
  input  logic               Clk,
  input  logic               clr_i,
  input  logic [COORD_W-1:0] tail_x_i,
  input  logic [COORD_W-1:0] tail_y_i,
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  logic               tail_opaque_i,
  output logic [ADDR_W-1:0]  tail_addr_o,
  output logic               hit_o
);
  logic [COORD_W-1:0] tx_q, ty_q;
  logic               box_q;

  always_ff @(posedge Clk) begin
    if (clr_i) begin
      tx_q  <= '0;
      ty_q  <= '0;
      box_q <= 1'b0;
    end else begin
      tx_q  <= tail_x_i;
      ty_q  <= tail_y_i;
      box_q <= in_box(tx_q, ty_q, pos_x_i, pos_y_i, ITEM_W, ITEM_H);
    end
  end

  // box_q and the ROM answer both refer to the address issued last cycle.
  assign tail_addr_o = sprite_addr(tx_q, ty_q, pos_x_i, pos_y_i, ITEM_W);
  assign hit_o       = box_q & tail_opaque_i;
endmodule

// File: rtl/catch_item.sv
// catch_item: catchable playfield object (gold/diamond/rock).
//   Clk, reset, new_game  - clock, synchronous active-high reset / re-arm
//   origin_x/y, weight    - spawn point, speed divisor (0 acts as 1)
//   value                 - score on collection
//   DrawX/DrawY, pix_addr, is_item - VGA-side sprite lookup
//   claw                  - per-claw tails, directions, events, hooked one-hot
//   collected/destroyed   - one-cycle terminal pulses; score_out with collected
//   gone, state_out       - terminal level, FSM state
module catch_item import catch_pkg::*; #(
  parameter int                      NUM_CLAWS = 2,
  parameter int                      ITEM_W    = 20,
  parameter int                      ITEM_H    = 20,
  parameter int                      TICK_DIV  = 2000000,
  parameter int                      ARRIVE_R2 = 40,
  parameter logic [NUM_CLAWS*10-1:0] HOME_X    = {10'd130, 10'd430},
  parameter logic [NUM_CLAWS*10-1:0] HOME_Y    = {10'd70, 10'd70}
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [2:0]         weight,
  input  logic [7:0]         value,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  catch_item_if.slave        claw,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic               is_item,
  output logic               collected,
  output logic               destroyed,
  output logic [7:0]         score_out,
  output logic               gone,
  output logic [2:0]         state_out
);
  localparam int KW = (NUM_CLAWS > 1) ? $clog2(NUM_CLAWS) : 1;
  localparam int TW = $clog2(TICK_DIV * 7 + 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [9:0]     s_q, s_d;
  logic [TW-1:0]  tick_q, tick_d, lim_q, lim_d, lim_new;
  logic           col_q, col_d, des_q, des_d;
  logic [7:0]     score_q, score_d;

  logic               clr;
  logic [NUM_CLAWS-1:0] hit;
  logic [3:0]         dir_a [NUM_CLAWS];
  logic [9:0]         hx_a  [NUM_CLAWS];
  logic [9:0]         hy_a  [NUM_CLAWS];
  logic               any_hit;
  logic [KW-1:0]      hit_idx;
  logic [COORD_W-1:0] pos_x, pos_y, mx, my;
  delta_t             dd;
  logic [2:0]         wt;
  logic signed [10:0] ex, ey;
  logic signed [21:0] exw, eyw;
  logic [21:0]        d2;
  logic               arrive;

  assign clr = reset | new_game;

  for (genvar g = 0; g < NUM_CLAWS; g++) begin : g_claw
    assign dir_a[g] = claw.claw_dir[g*4 +: 4];
    assign hx_a[g]  = HOME_X[g*10 +: 10];
    assign hy_a[g]  = HOME_Y[g*10 +: 10];
    catch_hit_pipe #(.ITEM_W(ITEM_W), .ITEM_H(ITEM_H)) u_pipe (
      .Clk          (Clk),
      .clr_i        (clr),
      .tail_x_i     (claw.tail_x[g*10 +: 10]),
      .tail_y_i     (claw.tail_y[g*10 +: 10]),
      .pos_x_i      (pos_x),
      .pos_y_i      (pos_y),
      .tail_opaque_i(claw.tail_opaque[g]),
      .tail_addr_o  (claw.tail_addr[g*19 +: 19]),
      .hit_o        (hit[g])
    );
  end

  // Lowest-index hitting claw wins.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CLAWS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        hit_idx = KW'(i);
      end
    end
  end

  // Position is origin + delta*s; low 10 bits of the sign-extended product
  // give the required mod-1024 wrap. s_q is 0 outside a drag.
  assign dd    = dir_delta(dir_a[k_q]);
  assign mx    = 10'($signed(dd.dx) * $signed({1'b0, s_q}));
  assign my    = 10'($signed(dd.dy) * $signed({1'b0, s_q}));
  assign pos_x = origin_x + mx;
  assign pos_y = origin_y + my;

  assign ex     = $signed({1'b0, pos_x}) - $signed({1'b0, hx_a[k_q]});
  assign ey     = $signed({1'b0, pos_y}) - $signed({1'b0, hy_a[k_q]});
  assign exw    = {{11{ex[10]}}, ex};
  assign eyw    = {{11{ey[10]}}, ey};
  assign d2     = 22'(exw * exw) + 22'(eyw * eyw);
  assign arrive = (d2 <= 22'(ARRIVE_R2));

  assign wt      = (weight == 3'd0) ? 3'd1 : weight;
  assign lim_new = TW'(TICK_DIV * int'(wt) - 1);

  always_ff @(posedge Clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      tick_q  <= '0;
      lim_q   <= '0;
      col_q   <= 1'b0;
      des_q   <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      tick_q  <= tick_d;
      lim_q   <= lim_d;
      col_q   <= col_d;
      des_q   <= des_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    tick_d  = tick_q;
    lim_d   = lim_q;
    col_d   = 1'b0;
    des_d   = 1'b0;
    score_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_hit) begin
          state_d = ST_HOOKED;
          k_d     = hit_idx;
          s_d     = '0;
          tick_d  = '0;
          lim_d   = lim_new;
        end
      end
      ST_HOOKED: begin
        // The period length is latched at each wrap so a weight change
        // only affects the following period.
        if (tick_q == lim_q) begin
          tick_d = '0;
          lim_d  = lim_new;
          if (s_q != 10'd1023) s_d = s_q + 10'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (claw.explode[k_q]) begin
          state_d = ST_DESTROYED;
          des_d   = 1'b1;
        end else if (claw.claw_idle[k_q] || arrive) begin
          state_d = ST_COLLECTED;
          col_d   = 1'b1;
          score_d = value;
        end
      end
      default: ;
    endcase
  end

  assign claw.hooked = (state_q == ST_HOOKED) ? (NUM_CLAWS'(1) << k_q) : '0;
  assign collected   = col_q;
  assign destroyed   = des_q;
  assign score_out   = score_q;
  assign gone        = (state_q == ST_COLLECTED) || (state_q == ST_DESTROYED);
  assign state_out   = state_q;
  assign pix_addr    = sprite_addr(DrawX, DrawY, pos_x, pos_y, ITEM_W);
  assign is_item     = !gone && in_box(DrawX, DrawY, pos_x, pos_y, ITEM_W, ITEM_H);
endmodule

// File: tb/tb_catch_item.sv
// tb_catch_item: directed-vector bench for catch_item with TICK_DIV=4.
// Default homes: claw 0 -> (430,70), claw 1 -> (130,70) (LSB slot = claw 0).
module tb_catch_item;
  logic       Clk = 1'b0;
  logic       reset, new_game;
  logic [9:0] origin_x, origin_y, DrawX, DrawY;
  logic [2:0] weight;
  logic [7:0] value;
  logic [18:0] pix_addr;
  logic       is_item, collected, destroyed, gone;
  logic [7:0] score_out;
  logic [2:0] state_out;
  int         n_cmp = 0;
  int         n_err = 0;

  catch_item_if #(.NUM_CLAWS(2)) cif ();

  catch_item #(.NUM_CLAWS(2), .ITEM_W(20), .ITEM_H(20), .TICK_DIV(4), .ARRIVE_R2(40)) dut (
    .Clk(Clk), .reset(reset), .new_game(new_game),
    .origin_x(origin_x), .origin_y(origin_y), .weight(weight), .value(value),
    .DrawX(DrawX), .DrawY(DrawY), .claw(cif),
    .pix_addr(pix_addr), .is_item(is_item), .collected(collected),
    .destroyed(destroyed), .score_out(score_out), .gone(gone), .state_out(state_out)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tail(input int c, input logic [9:0] x, input logic [9:0] y);
    cif.tail_x[c*10 +: 10] = x;
    cif.tail_y[c*10 +: 10] = y;
  endtask

  task automatic do_reset();
    set_tail(0, 10'd0, 10'd0);
    set_tail(1, 10'd0, 10'd0);
    cif.explode   = 2'b00;
    cif.claw_idle = 2'b00;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0;
    origin_x = 10'd200; origin_y = 10'd300; weight = 3'd2; value = 8'h5A;
    DrawX = 10'd200; DrawY = 10'd300;
    cif.tail_x = '0; cif.tail_y = '0; cif.claw_dir = {4'd0, 4'd5};
    cif.claw_idle = '0; cif.explode = '0; cif.tail_opaque = 2'b11;
    tick(2);
    reset = 1'b0;

    // Reset state and rendering box edges at origin (200,300)
    chk("rst_state", state_out, 0);
    chk("rst_hooked", cif.hooked, 0);
    chk("rst_gone", gone, 0);
    chk("rst_score", score_out, 0);
    chk("rst_coll", collected, 0);
    chk("pix_tl_in", is_item, 1);
    chk("pix_tl_addr", pix_addr, 0);
    DrawX = 10'd219; DrawY = 10'd319; #1;
    chk("pix_br_in", is_item, 1);
    chk("pix_br_addr", pix_addr, 399);
    DrawX = 10'd220; #1;
    chk("pix_right_out", is_item, 0);
    DrawX = 10'd200; DrawY = 10'd299; #1;
    chk("pix_top_out", is_item, 0);
    DrawY = 10'd300;

    // Transparent pixel never hooks
    cif.tail_opaque = 2'b00;
    set_tail(0, 10'd205, 10'd305);
    tick(4);
    chk("transp_state", state_out, 0);
    set_tail(0, 10'd0, 10'd0);
    tick(3);
    cif.tail_opaque = 2'b11;

    // Hook latency 3 cycles, tail address (5*20+5)
    set_tail(0, 10'd205, 10'd305);
    tick(1);
    chk("tail_addr0", cif.tail_addr[18:0], 105);
    chk("hook_lat1", cif.hooked, 0);
    tick(1);
    chk("hook_lat2", cif.hooked, 0);
    tick(1);
    chk("hook_lat3", cif.hooked, 2'b01);
    chk("hook_state", state_out, 1);

    // weight 2: step every 8 cycles, dir 5 -> y -6 (addr at DrawY=300 += 120)
    tick(7);
    chk("w2_s0", pix_addr, 0);
    tick(1);
    chk("w2_s1", pix_addr, 120);
    tick(7);
    chk("w2_s1_hold", pix_addr, 120);
    tick(1);
    chk("w2_s2", pix_addr, 240);

    // Simultaneous hits -> claw 0; claw 1 explode ignored
    do_reset();
    set_tail(0, 10'd205, 10'd305);
    set_tail(1, 10'd205, 10'd305);
    tick(3);
    chk("sim_hooked", cif.hooked, 2'b01);
    cif.explode = 2'b10;
    tick(2);
    chk("sim_ex1_state", state_out, 1);
    chk("sim_ex1_des", destroyed, 0);
    cif.explode = 2'b01;
    tick(1);
    chk("ex0_des", destroyed, 1);
    chk("ex0_state", state_out, 3);
    chk("ex0_gone", gone, 1);
    chk("ex0_score", score_out, 0);
    cif.explode = 2'b00;
    tick(1);
    chk("ex0_pulse_end", destroyed, 0);
    chk("ex0_gone_hold", gone, 1);

    // Claw 1 collection: origin (142,70), dir 10, home (130,70).
    // Step 0 dist^2=144, step 1 at (136,70) dist^2=36 <= 40.
    origin_x = 10'd142; origin_y = 10'd70; weight = 3'd1;
    cif.claw_dir = {4'd10, 4'd0};
    do_reset();
    set_tail(1, 10'd145, 10'd75);
    tick(3);
    chk("c1_hooked", cif.hooked, 2'b10);
    tick(3);
    chk("c1_pre_state", state_out, 1);
    tick(1);
    DrawX = 10'd136; DrawY = 10'd70; #1;
    chk("c1_step_state", state_out, 1);
    chk("c1_step_addr", pix_addr, 0);
    chk("c1_step_in", is_item, 1);
    tick(1);
    chk("c1_coll", collected, 1);
    chk("c1_score", score_out, 8'h5A);
    chk("c1_state", state_out, 2);
    chk("c1_gone", gone, 1);
    chk("c1_is_item", is_item, 0);
    chk("c1_hooked_off", cif.hooked, 0);
    tick(1);
    chk("c1_pulse_end", collected, 0);
    chk("c1_score_end", score_out, 0);

    // Explode and arrival the same cycle: origin (436,70), claw 0 home (430,70)
    origin_x = 10'd436; origin_y = 10'd70;
    do_reset();
    set_tail(0, 10'd440, 10'd75);
    cif.explode = 2'b01;
    tick(3);
    chk("exarr_hooked", cif.hooked, 2'b01);
    tick(1);
    chk("exarr_des", destroyed, 1);
    chk("exarr_coll", collected, 0);
    chk("exarr_score", score_out, 0);
    chk("exarr_state", state_out, 3);
    cif.explode = 2'b00;

    // weight 0 acts as 1 (step every 4), then new_game mid-drag and re-hook
    origin_x = 10'd200; origin_y = 10'd300; weight = 3'd0;
    cif.claw_dir = {4'd0, 4'd5};
    DrawX = 10'd200; DrawY = 10'd300;
    do_reset();
    set_tail(0, 10'd205, 10'd305);
    tick(3);
    chk("w0_hooked", cif.hooked, 2'b01);
    tick(3);
    chk("w0_s0", pix_addr, 0);
    tick(1);
    chk("w0_s1", pix_addr, 120);
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    chk("ng_state", state_out, 0);
    chk("ng_hooked", cif.hooked, 0);
    chk("ng_coll", collected, 0);
    chk("ng_des", destroyed, 0);
    chk("ng_pos", pix_addr, 0);
    tick(3);
    chk("ng_rehook", cif.hooked, 2'b01);
    chk("ng_rehook_state", state_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
